// File: rtl/mux_scan_pkg.sv
// rtl/mux_scan_pkg.sv - shared types and constants for the MUX scan sequencer
package mux_scan_pkg;

   // Scan sequencer states. The encoding is fixed so that waveforms match the lab documentation.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } scan_state_t;

   localparam int NUM_CH = 4;
   localparam int SEL_W  = 2;

   // True when the select points at the final channel of a scan.
   function automatic logic is_last_ch(input logic [SEL_W-1:0] sel);
      return sel == SEL_W'(NUM_CH - 1);
   endfunction

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// rtl/mux_scan_ctrl_if.sv - request, select and capture signals between sequencer and MUX/SoC
interface mux_scan_ctrl_if;
   import mux_scan_pkg::*;

   logic              start;
   logic              mux_out;
   logic              sel1;
   logic              sel0;
   logic              busy;
   logic              done;
   logic [NUM_CH-1:0] data;

   // Sequencer side: drives the MUX selects and the captured word.
   modport master (
      input  start,
      input  mux_out,
      output sel1,
      output sel0,
      output busy,
      output done,
      output data
   );

   // SoC/MUX side: requests scans and returns the selected bit.
   modport slave (
      output start,
      output mux_out,
      input  sel1,
      input  sel0,
      input  busy,
      input  done,
      input  data
   );

endinterface

// File: rtl/mux_scan_ctrl_dwell_timer.sv
// rtl/mux_scan_ctrl_dwell_timer.sv - settle-time counter that flags the last dwell cycle
module dwell_timer #(
   parameter int DWELL = 2,
   parameter int CNT_W = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [CNT_W-1:0] cnt_q;

   // Dwell count: clear has priority so a new channel always starts from zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (enable) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign expired = (cnt_q == CNT_W'(DWELL - 1));

endmodule

// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - 4-channel MUX select sequencer and bit capture (option: MUX_SCAN_CONTINUOUS_EN)
module mux_scan_ctrl
   import mux_scan_pkg::*;
#(
   parameter int DWELL = 2,
   parameter int CNT_W = 4
) (
   input  logic           clk,
   input  logic           reset,
   mux_scan_ctrl_if.master bus
);

   scan_state_t       state_q;
   scan_state_t       state_d;
   logic [SEL_W-1:0]  sel_q;
   logic [SEL_W-1:0]  sel_d;
   logic [NUM_CH-1:0] shadow_q;
   logic [NUM_CH-1:0] shadow_d;
   logic [NUM_CH-1:0] data_q;
   logic [NUM_CH-1:0] data_d;
   logic              tmr_clear;
   logic              tmr_enable;
   logic              tmr_expired;

   dwell_timer #(
      .DWELL (DWELL),
      .CNT_W (CNT_W)
   ) u_dwell (
      .clk     (clk),
      .reset   (reset),
      .clear   (tmr_clear),
      .enable  (tmr_enable),
      .expired (tmr_expired)
   );

   // State, select, shadow and published-word registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         sel_q    <= '0;
         shadow_q <= '0;
         data_q   <= '0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         shadow_q <= shadow_d;
         data_q   <= data_d;
      end
   end

   // Next-state logic; the select only moves on the SAMPLE->SETTLE edge, never while sampling.
   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      shadow_d   = shadow_q;
      data_d     = data_q;
      tmr_enable = 1'b0;
      tmr_clear  = 1'b1;
      case (state_q)
         IDLE: begin
            sel_d = '0;
            if (bus.start) begin
               state_d = SETTLE;
            end
         end
         SETTLE: begin
            tmr_enable = 1'b1;
            tmr_clear  = tmr_expired;
            if (tmr_expired) begin
               state_d = SAMPLE;
            end
         end
         SAMPLE: begin
            shadow_d[sel_q] = bus.mux_out;
            if (is_last_ch(sel_q)) begin
               // Publish the whole word at once, including the bit captured on this edge.
               data_d  = shadow_d;
               state_d = DONE;
            end else begin
               sel_d   = sel_q + 1'b1;
               state_d = SETTLE;
            end
         end
         DONE: begin
            sel_d = '0;
`ifdef MUX_SCAN_CONTINUOUS_EN
            state_d = bus.start ? SETTLE : IDLE;
`else
            state_d = IDLE;
`endif
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.sel1 = sel_q[1];
   assign bus.sel0 = sel_q[0];
   assign bus.busy = (state_q != IDLE);
   assign bus.done = (state_q == DONE);
   assign bus.data = data_q;

endmodule
